// File: rtl/pipe_sink.sv
// Tail consumer for a pipe_reg chain: buffers the last stage's beats in a small
// FIFO and re-presents them on a valid/ready port with occupancy and beat count.
module pipe_sink #(
  parameter int DSIZE = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       valid,
  input  logic [DSIZE-1:0]           indata,
  output logic                       low_empty,
  output logic                       out_vld,
  output logic [DSIZE-1:0]           out_data,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           beat_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             push, pop;

  // No ready pass-through: a full FIFO refuses input even if it pops this cycle.
  assign low_empty = (level_q != LW'(DEPTH)) & ~flush;
  assign out_vld   = (level_q != '0);
  assign push      = valid & low_empty;
  assign pop       = out_vld & out_rdy & ~flush;

  assign out_data  = out_vld ? mem[rd_ptr_q] : '0;
  assign level     = level_q;
  assign beat_cnt  = beat_cnt_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    beat_cnt_d = beat_cnt_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      beat_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Storage carries no reset; stale words are hidden by the out_vld gate.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= indata;
  end

endmodule
